// File: rtl/exponent_scheduler.sv
// exponent_scheduler: round-robin arbiter that shares one W-bit exponent unit
// (enable/ready handshake, result on p) among N_REQ requesters. It latches the
// winner's operands, issues them, waits out the unit's ready handshake, and
// returns the result to the winner. It also drives the unit's active-low reset.
//
// Optional feature: define EXPSCHED_TIMEOUT_EN to bound the wait states by
// TIMEOUT_CYCLES. On expiry the unit is reset for one cycle and the winner
// receives rsp_p=0 with rsp_err=1. Without the macro the scheduler waits
// indefinitely and rsp_err is tied low.
module exponent_scheduler #(
  parameter int N_REQ          = 4,
  parameter int W              = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_x,
  input  logic [N_REQ*W-1:0] req_a,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_p,
  output logic               rsp_err,
  output logic               busy,
  output logic               exp_enable,
  output logic [W-1:0]       exp_x,
  output logic [W-1:0]       exp_a,
  input  logic [W-1:0]       exp_p,
  input  logic               exp_ready,
  output logic               exp_reset_n
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_DONE,
    S_RESP,
    S_ABORT
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;     // round-robin start position
  logic [IDX_W-1:0]   win_q;     // requester currently being served
  logic [IDX_W-1:0]   ptr_d;     // pointer after serving win_q
  logic [IDX_W-1:0]   win_idx;   // combinational arbitration result
  logic [N_REQ-1:0]   win_onehot;
  logic [N_REQ-1:0]   grant_onehot;
  int                 pos;

  // Round-robin search: first set req_valid bit at or above ptr_q, wrapping.
  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    win_idx = ptr_q;
    pos     = 0;
    // Scan from the farthest offset down so the nearest requester wins last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr_q) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (req_valid[pos]) win_idx = IDX_W'(pos);
    end
  end

  // One-hot decodes of the fresh winner and of the latched winner, plus the
  // pointer that follows the latched winner.
  always_comb begin
    grant_onehot = N_REQ'(1) << win_idx;
    win_onehot   = N_REQ'(1) << win_q;
    ptr_d        = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
  end

`ifdef EXPSCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_hit;

  // Expiry flag for the wait-state cycle counter.
  always_comb begin
    timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // The unit is held in reset with the scheduler and for the single ABORT cycle.
  assign exp_reset_n = ~reset & (state_q != S_ABORT);
`else
  // The unit's reset simply follows the scheduler's reset.
  assign exp_reset_n = ~reset;
  assign rsp_err     = 1'b0;
`endif

  // Scheduler FSM with all outputs registered; ack/valid/enable are one-cycle
  // pulses set on entry to their state and cleared by default afterwards.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      req_ack    <= '0;
      rsp_valid  <= '0;
      rsp_p      <= '0;
      busy       <= 1'b0;
      exp_enable <= 1'b0;
      exp_x      <= '0;
      exp_a      <= '0;
`ifdef EXPSCHED_TIMEOUT_EN
      rsp_err    <= 1'b0;
      cnt_q      <= '0;
`endif
    end else begin
      req_ack    <= '0;
      rsp_valid  <= '0;
      exp_enable <= 1'b0;
`ifdef EXPSCHED_TIMEOUT_EN
      if (state_q == S_WAIT_LOW || state_q == S_WAIT_DONE) cnt_q <= cnt_q + 1'b1;
`endif
      case (state_q)
        S_IDLE: begin
          if (exp_ready && |req_valid) begin
            exp_x      <= req_x[win_idx*W +: W];
            exp_a      <= req_a[win_idx*W +: W];
            win_q      <= win_idx;
            req_ack    <= grant_onehot;
            exp_enable <= 1'b1;
            busy       <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef EXPSCHED_TIMEOUT_EN
          cnt_q   <= '0;
`endif
          state_q <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
`ifdef EXPSCHED_TIMEOUT_EN
          if (timeout_hit) state_q <= S_ABORT;
          else
`endif
          if (!exp_ready) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // A capture in the expiry cycle takes priority over the abort.
          if (exp_ready) begin
            rsp_p     <= exp_p;
            rsp_valid <= win_onehot;
`ifdef EXPSCHED_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state_q   <= S_RESP;
          end
`ifdef EXPSCHED_TIMEOUT_EN
          else if (timeout_hit) begin
            state_q <= S_ABORT;
          end
`endif
        end
`ifdef EXPSCHED_TIMEOUT_EN
        S_ABORT: begin
          rsp_p     <= '0;
          rsp_err   <= 1'b1;
          rsp_valid <= win_onehot;
          state_q   <= S_RESP;
        end
`endif
        S_RESP: begin
          // The unit leaves DONE during this cycle, so IDLE never sees it there.
          ptr_q   <= ptr_d;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
